// File: rtl/instr_encoder.sv
// Encodes register-form operation requests into 32-bit instruction words and
// buffers them in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_op,
    input  logic [4:0]               req_rs,
    input  logic [4:0]               req_rt,
    input  logic [4:0]               req_rd,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instruction,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_illegal,
    output logic [15:0]              issued_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] OP_NOP = 3'd4;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [15:0]   issued_q, issued_d;

    logic          accept;
    logic          enqueue;
    logic          dequeue;
    logic [31:0]   enc_word;

    function automatic logic [31:0] encode(
        input logic [2:0] op,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd
    );
        logic [31:0] word;
        word = 32'h0;
        if (op == OP_NOP) begin
            word = 32'hFC00_0000;
        end else if (op < OP_NOP) begin
            word = {3'b000, op, rs, rt, rd, 11'b0};
        end
        return word;
    endfunction

    assign req_ready    = (count_q != CW'(DEPTH));
    assign instr_valid  = (count_q != '0);
    // Gate the head word so stale storage never leaks out while empty.
    assign instruction  = instr_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign fifo_count   = count_q;
    assign err_illegal  = err_q;
    assign issued_count = issued_q;

    always_comb begin
        accept   = req_valid && req_ready;
        enqueue  = accept && (req_op <= OP_NOP);
        dequeue  = instr_valid && instr_ready;
        enc_word = encode(req_op, req_rs, req_rt, req_rd);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        issued_d = issued_q;
        err_d    = accept && (req_op > OP_NOP);

        if (enqueue) begin
            mem_d[wr_ptr_q] = enc_word;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (dequeue) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            issued_d = issued_q + 16'd1;
        end
        if (enqueue && !dequeue) begin
            count_d = count_q + CW'(1);
        end else if (!enqueue && dequeue) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            issued_q <= 16'h0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            issued_q <= issued_d;
        end
    end

    // Storage is deliberately left unreset; the count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table-driven encoding vectors plus
// model-checked sequences for backpressure, full-rate streaming and reset.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [2:0]  fifo_count;
    logic        err_illegal;
    logic [15:0] issued_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [15:0] m_issued;
    logic        m_err;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] word;
        logic        illegal;
    } vec_t;

    vec_t vecs[8];

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rs       (req_rs),
        .req_rt       (req_rt),
        .req_rd       (req_rd),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instruction  (instruction),
        .fifo_count   (fifo_count),
        .err_illegal  (err_illegal),
        .issued_count (issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd, input logic rdy);
        req_valid   = v;
        req_op      = op;
        req_rs      = rs;
        req_rt      = rt;
        req_rd      = rd;
        instr_ready = rdy;
    endtask

    function automatic logic [31:0] ref_word(input int op, input int rs, input int rt, input int rd);
        if (op == 4) return 32'hFC00_0000;
        return 32'((op << 26) | (rs << 21) | (rt << 16) | (rd << 11));
    endfunction

    // Drive one cycle, compare current outputs against the queue model, then advance both.
    task automatic runCycle(input logic v, input logic [2:0] op, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd, input logic rdy);
        int  sz;
        bit  acc;
        bit  pop;
        applyStimulus(v, op, rs, rt, rd, rdy);
        sz = exp_q.size();
        checkOutput("req_ready", {31'b0, req_ready}, {31'b0, sz != DEPTH});
        checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, sz != 0});
        checkOutput("instruction", instruction, (sz != 0) ? exp_q[0] : 32'h0);
        checkOutput("fifo_count", {29'b0, fifo_count}, 32'(sz));
        checkOutput("err_illegal", {31'b0, err_illegal}, {31'b0, m_err});
        checkOutput("issued_count", {16'b0, issued_count}, {16'b0, m_issued});
        acc   = v && (sz != DEPTH);
        pop   = (sz != 0) && rdy;
        m_err = acc && (op > 3'd4);
        if (pop) begin
            void'(exp_q.pop_front());
            m_issued = m_issued + 16'd1;
        end
        if (acc && op <= 3'd4) exp_q.push_back(ref_word(int'(op), int'(rs), int'(rt), int'(rd)));
        step();
    endtask

    initial begin
        logic [15:0] iss;
        vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  32'h0022_1800, 1'b0};
        vecs[1] = '{3'd3, 5'd31, 5'd31, 5'd31, 32'h0FFF_F800, 1'b0};
        vecs[2] = '{3'd4, 5'd7,  5'd9,  5'd11, 32'hFC00_0000, 1'b0};
        vecs[3] = '{3'd1, 5'd5,  5'd6,  5'd7,  32'h04A6_3800, 1'b0};
        vecs[4] = '{3'd2, 5'd10, 5'd20, 5'd0,  32'h0954_0000, 1'b0};
        vecs[5] = '{3'd6, 5'd1,  5'd2,  5'd3,  32'h0000_0000, 1'b1};
        vecs[6] = '{3'd5, 5'd31, 5'd0,  5'd31, 32'h0000_0000, 1'b1};
        vecs[7] = '{3'd7, 5'd4,  5'd4,  5'd4,  32'h0000_0000, 1'b1};

        rst_n = 1'b0;
        applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        step();
        step();
        rst_n = 1'b1;
        checkOutput("rst_fifo_count", {29'b0, fifo_count}, 32'h0);
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("rst_instruction", instruction, 32'h0);
        checkOutput("rst_err_illegal", {31'b0, err_illegal}, 32'h0);
        checkOutput("rst_issued_count", {16'b0, issued_count}, 32'h0);

        $display("[TB] encoding vectors");
        iss = 16'd0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, 1'b1);
            step();
            applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1);
            checkOutput("vec_instr_valid", {31'b0, instr_valid}, {31'b0, !vecs[i].illegal});
            checkOutput("vec_instruction", instruction, vecs[i].word);
            checkOutput("vec_fifo_count", {29'b0, fifo_count}, {31'b0, !vecs[i].illegal});
            checkOutput("vec_err_illegal", {31'b0, err_illegal}, {31'b0, vecs[i].illegal});
            checkOutput("vec_issued_hold", {16'b0, issued_count}, {16'b0, iss});
            step();
            if (!vecs[i].illegal) iss = iss + 16'd1;
            checkOutput("vec_issued_after", {16'b0, issued_count}, {16'b0, iss});
            checkOutput("vec_drained", {29'b0, fifo_count}, 32'h0);
            checkOutput("vec_err_clear", {31'b0, err_illegal}, 32'h0);
            checkOutput("vec_idle_instruction", instruction, 32'h0);
        end
        m_issued = iss;
        m_err    = 1'b0;
        exp_q.delete();

        $display("[TB] backpressure and drain");
        for (int i = 0; i < 4; i++) begin
            runCycle(1'b1, 3'(i % 4), 5'(i + 1), 5'(2 * i), 5'(31 - i), 1'b0);
        end
        runCycle(1'b1, 3'd0, 5'd5, 5'd8, 5'd27, 1'b0);
        runCycle(1'b1, 3'd0, 5'd5, 5'd8, 5'd27, 1'b0);
        for (int k = 0; k < 4; k++) begin
            bit will_acc;
            will_acc = (exp_q.size() != DEPTH);
            runCycle(1'b1, 3'd0, 5'd5, 5'd8, 5'd27, 1'b1);
            if (will_acc) break;
        end
        for (int k = 0; k < 6; k++) begin
            runCycle(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        end
        checkOutput("drain_empty", {29'b0, fifo_count}, 32'h0);

        $display("[TB] illegal op mid-stream");
        runCycle(1'b1, 3'd1, 5'd3, 5'd4, 5'd5, 1'b0);
        runCycle(1'b1, 3'd6, 5'd9, 5'd9, 5'd9, 1'b0);
        runCycle(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        runCycle(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        runCycle(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1);

        $display("[TB] full-rate streaming");
        runCycle(1'b1, 3'd2, 5'd1, 5'd2, 5'd3, 1'b0);
        runCycle(1'b1, 3'd3, 5'd4, 5'd5, 5'd6, 1'b0);
        for (int k = 0; k < 20; k++) begin
            runCycle(1'b1, 3'(k % 5), 5'(k), 5'(k + 3), 5'(k + 7), 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            runCycle(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        end
        checkOutput("stream_empty", {29'b0, fifo_count}, 32'h0);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) begin
            runCycle(1'b1, 3'd0, 5'(i), 5'(i), 5'(i), 1'b0);
        end
        rst_n = 1'b0;
        applyStimulus(1'b1, 3'd1, 5'd7, 5'd7, 5'd7, 1'b0);
        step();
        rst_n = 1'b1;
        applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        exp_q.delete();
        m_issued = 16'd0;
        m_err    = 1'b0;
        runCycle(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        runCycle(1'b1, 3'd3, 5'd2, 5'd2, 5'd2, 1'b1);
        runCycle(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        runCycle(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
